// File: rtl/fetch_inst_queue.sv
// Instruction queue between the fetch/memory-response side and the decoder.
// Holds fetched words with PC, fault and branch-predict sideband, and presents
// the oldest entry to the decoder. A faulting fetch locks the input side until
// the queue is flushed. The head is read combinationally, so the earliest an
// entry reaches the decoder is the cycle after it was accepted.
module fetch_inst_queue #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFREE_DEFAULT,
    input  logic                 iPREVIOUS_VALID,
    input  logic                 iPREVIOUS_FAULT_PAGEFAULT,
    input  logic                 iPREVIOUS_FAULT_PRIVILEGE_ERROR,
    input  logic                 iPREVIOUS_FAULT_INVALID_INST,
    input  logic                 iPREVIOUS_PAGING_ENA,
    input  logic                 iPREVIOUS_KERNEL_ACCESS,
    input  logic                 iPREVIOUS_BRANCH_PREDICT,
    input  logic [31:0]          iPREVIOUS_BRANCH_PREDICT_ADDR,
    input  logic [31:0]          iPREVIOUS_INST,
    input  logic [31:0]          iPREVIOUS_PC,
    output logic                 oPREVIOUS_LOCK,
    output logic                 oNEXT_INST_VALID,
    output logic                 oNEXT_FAULT_PAGEFAULT,
    output logic                 oNEXT_FAULT_PRIVILEGE_ERROR,
    output logic                 oNEXT_FAULT_INVALID_INST,
    output logic                 oNEXT_PAGING_ENA,
    output logic                 oNEXT_KERNEL_ACCESS,
    output logic                 oNEXT_BRANCH_PREDICT,
    output logic [31:0]          oNEXT_BRANCH_PREDICT_ADDR,
    output logic [31:0]          oNEXT_INST,
    output logic [31:0]          oNEXT_PC,
    input  logic                 iNEXT_LOCK,
    output logic                 oFAULT_HOLD,
    output logic [DEPTH_N:0]     oCOUNT
);

    localparam int                ENTRY_W    = 102;
    localparam logic [DEPTH_N:0]  FULL_COUNT = (DEPTH_N+1)'(DEPTH);

    typedef enum logic {
        FILL       = 1'b0,
        FAULT_HOLD = 1'b1
    } state_t;

    // Entry layout: {pagefault, privilege, invalid, paging, kernel, predict,
    //                predict_addr[31:0], inst[31:0], pc[31:0]}
    logic [ENTRY_W-1:0] entry_mem [0:DEPTH-1];

    logic [DEPTH_N-1:0] rd_ptr_reg;
    logic [DEPTH_N-1:0] wr_ptr_reg;
    logic [DEPTH_N:0]   count_reg;
    state_t             state_reg;

    logic               lock;
    logic               push;
    logic               pop;
    logic               push_fault;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Input is refused while full (even if a pop happens this cycle) or after a fault.
    assign lock = (count_reg == FULL_COUNT) || (state_reg == FAULT_HOLD);
    assign push = iPREVIOUS_VALID && !lock && !iFREE_DEFAULT;
    assign pop  = (count_reg != '0) && !iNEXT_LOCK && !iFREE_DEFAULT;

    assign push_fault = iPREVIOUS_FAULT_PAGEFAULT || iPREVIOUS_FAULT_PRIVILEGE_ERROR ||
                        iPREVIOUS_FAULT_INVALID_INST;

    assign push_entry = {iPREVIOUS_FAULT_PAGEFAULT, iPREVIOUS_FAULT_PRIVILEGE_ERROR,
                         iPREVIOUS_FAULT_INVALID_INST, iPREVIOUS_PAGING_ENA,
                         iPREVIOUS_KERNEL_ACCESS, iPREVIOUS_BRANCH_PREDICT,
                         iPREVIOUS_BRANCH_PREDICT_ADDR, iPREVIOUS_INST, iPREVIOUS_PC};

    // Entry storage; contents need no reset because count masks them.
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            entry_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers, occupancy and fault-hold state; flush dominates push and pop.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= FILL;
        end else if (iFREE_DEFAULT) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= FILL;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_N'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_N'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (DEPTH_N+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (DEPTH_N+1)'(1);
            end
            if (push && push_fault) begin
                state_reg <= FAULT_HOLD;
            end
        end
    end

    // Head presentation, forced to zero while empty so no stale entry is visible.
    always_comb begin
        head_entry = '0;
        if (count_reg != '0) begin
            head_entry = entry_mem[rd_ptr_reg];
        end
    end

    assign {oNEXT_FAULT_PAGEFAULT, oNEXT_FAULT_PRIVILEGE_ERROR, oNEXT_FAULT_INVALID_INST,
            oNEXT_PAGING_ENA, oNEXT_KERNEL_ACCESS, oNEXT_BRANCH_PREDICT,
            oNEXT_BRANCH_PREDICT_ADDR, oNEXT_INST, oNEXT_PC} = head_entry;

    assign oNEXT_INST_VALID = (count_reg != '0);
    assign oPREVIOUS_LOCK   = lock;
    assign oFAULT_HOLD      = (state_reg == FAULT_HOLD);
    assign oCOUNT           = count_reg;

endmodule
